// File: rtl/poc_bus_arbiter_if.sv
// Requester handshakes plus the POC register bus, bundled for the arbiter.
interface poc_bus_arbiter_if;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned COUNT_W = 16;

  // Requester 0 / requester 1 character handshakes
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  // Mode request and POC status inputs
  logic mode_sel;
  logic irq;
  logic reg_out;

  // POC register bus
  logic [DATA_W-1:0]  data_out;
  logic               rw;
  logic               reg_in;
  logic [ADDR_W-1:0]  addr;

  // Status
  logic               owner;
  logic               busy;
  logic               timeout_err;
  logic [COUNT_W-1:0] char_count;

  // Arbiter side
  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  mode_sel, irq, reg_out,
    output req0_ready, req1_ready,
    output data_out, rw, reg_in, addr,
    output owner, busy, timeout_err, char_count
  );

  // Environment side: character sources and the POC
  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data,
    output mode_sel, irq, reg_out,
    input  req0_ready, req1_ready,
    input  data_out, rw, reg_in, addr,
    input  owner, busy, timeout_err, char_count
  );
endinterface

// File: rtl/poc_bus_arbiter.sv
// Two-requester round-robin arbiter and POC write-transaction sequencer.
module poc_bus_arbiter #(
  parameter int unsigned POLL_TIMEOUT = 50000
) (
  input logic               clk,
  input logic               rst_n,
  poc_bus_arbiter_if.master bus
);

  localparam int unsigned TMO_W    = (POLL_TIMEOUT == 0) ? 1 : $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned TMO_LAST = (POLL_TIMEOUT == 0) ? 0 : POLL_TIMEOUT - 1;
  localparam bit          TMO_EN   = (POLL_TIMEOUT != 0);

  localparam logic [2:0] ADDR_SR0 = 3'b000;
  localparam logic [2:0] ADDR_BR  = 3'b100;
  localparam logic [2:0] ADDR_SR7 = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_WAIT_RDY,
    ST_WRITE_BR,
    ST_SET_BUSY
  } state_t;

  state_t             state;
  logic               cfg_pending;
  logic               cur_mode;
  logic               cfg_mode;
  logic               last_grant;
  logic               owner_q;
  logic               timeout_q;
  logic [7:0]         held;
  logic [TMO_W-1:0]   tmo;
  logic [15:0]        char_count_q;

  logic need_cfg_c;
  logic grant_c;
  logic grant_sel_c;
  logic rdy_cond_c;
  logic tmo_hit_c;

  // Arbitration decision and POC-ready condition for the current cycle
  always_comb begin
    need_cfg_c  = cfg_pending | (bus.mode_sel != cur_mode);
    grant_c     = (state == ST_IDLE) & ~need_cfg_c & (bus.req0_valid | bus.req1_valid);
    // Both valid: alternate away from the last winner; otherwise the lone requester wins
    grant_sel_c = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    rdy_cond_c  = cur_mode ? ~bus.irq : bus.reg_out;
    tmo_hit_c   = TMO_EN && (tmo == TMO_W'(TMO_LAST));
  end

  // Ready is the accept strobe for the granted requester in IDLE
  always_comb begin
    bus.req0_ready = grant_c & ~grant_sel_c;
    bus.req1_ready = grant_c &  grant_sel_c;
  end

  // Moore decode of the POC bus from the state register and held character
  always_comb begin
    bus.rw       = 1'b0;
    bus.addr     = ADDR_SR0;
    bus.data_out = 8'h00;
    bus.reg_in   = 1'b0;
    unique case (state)
      ST_CFG: begin
        bus.rw     = 1'b1;
        bus.addr   = ADDR_SR0;
        bus.reg_in = cfg_mode;
      end
      ST_WAIT_RDY: begin
        bus.addr = ADDR_SR7;
      end
      ST_WRITE_BR: begin
        bus.rw       = 1'b1;
        bus.addr     = ADDR_BR;
        bus.data_out = held;
      end
      ST_SET_BUSY: begin
        bus.rw   = 1'b1;
        bus.addr = ADDR_SR7;
      end
      default: begin
      end
    endcase
  end

  // Status outputs
  always_comb begin
    bus.owner       = owner_q;
    bus.busy        = (state != ST_IDLE);
    bus.timeout_err = timeout_q;
    bus.char_count  = char_count_q;
  end

  // Transaction sequencer: state, held character, mode tracking, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cfg_pending  <= 1'b1;
      cur_mode     <= 1'b0;
      cfg_mode     <= 1'b0;
      last_grant   <= 1'b1;
      owner_q      <= 1'b0;
      timeout_q    <= 1'b0;
      held         <= 8'h00;
      tmo          <= '0;
      char_count_q <= 16'h0000;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (need_cfg_c) begin
            // Snapshot the requested mode so the SR0 write and cur_mode agree
            cfg_mode <= bus.mode_sel;
            state    <= ST_CFG;
          end else if (grant_c) begin
            held       <= grant_sel_c ? bus.req1_data : bus.req0_data;
            owner_q    <= grant_sel_c;
            last_grant <= grant_sel_c;
            tmo        <= '0;
            state      <= ST_WAIT_RDY;
          end
        end
        ST_CFG: begin
          cur_mode    <= cfg_mode;
          cfg_pending <= 1'b0;
          state       <= ST_IDLE;
        end
        ST_WAIT_RDY: begin
          if (rdy_cond_c) begin
            state <= ST_WRITE_BR;
          end else if (tmo_hit_c) begin
            timeout_q <= 1'b1;
            held      <= 8'h00;
            state     <= ST_IDLE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ST_WRITE_BR: begin
          state <= ST_SET_BUSY;
        end
        ST_SET_BUSY: begin
          char_count_q <= char_count_q + 16'd1;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poc_bus_arbiter.sv
// Self-checking bench for poc_bus_arbiter: vector table, directed corners, random vs model.
module tb_poc_bus_arbiter;

  localparam int unsigned P_MAIN  = 16;
  localparam int unsigned P_SHORT = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poc_bus_arbiter_if bus ();
  poc_bus_arbiter_if bus2 ();

  poc_bus_arbiter #(.POLL_TIMEOUT(P_MAIN))  dut       (.clk(clk), .rst_n(rst_n), .bus(bus));
  poc_bus_arbiter #(.POLL_TIMEOUT(P_SHORT)) dut_short (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // ---------------- reference model (main DUT) ----------------
  // Tracks the transaction by elapsed cycles since the grant and the cycle at
  // which the POC first reported ready.
  bit         m_pending, m_mode, m_last, m_cfg_now, m_cfg_val, m_inflight, m_own, m_tmo_pulse;
  logic [7:0] m_held;
  int         m_n, m_rdy_n;
  logic [15:0] m_count;

  task automatic m_reset();
    m_pending = 1; m_mode = 0; m_last = 1; m_cfg_now = 0; m_cfg_val = 0;
    m_inflight = 0; m_own = 0; m_tmo_pulse = 0; m_held = 0; m_n = 0; m_rdy_n = -1;
    m_count = 0;
  endtask

  task automatic model_step();
    bit nxt_tmo;
    bit cond;
    int g;
    nxt_tmo = 0;
    chk("m_timeout", int'(bus.timeout_err), int'(m_tmo_pulse));
    chk("m_count", int'(bus.char_count), int'(m_count));
    if (m_cfg_now) begin
      chk("m_cfg_rw", int'(bus.rw), 1);
      chk("m_cfg_addr", int'(bus.addr), 0);
      chk("m_cfg_regin", int'(bus.reg_in), int'(m_cfg_val));
      chk("m_cfg_busy", int'(bus.busy), 1);
      chk("m_cfg_ready", int'({bus.req1_ready, bus.req0_ready}), 0);
      m_mode = m_cfg_val; m_pending = 0; m_cfg_now = 0;
    end else if (m_inflight) begin
      chk("m_xfer_busy", int'(bus.busy), 1);
      chk("m_xfer_ready", int'({bus.req1_ready, bus.req0_ready}), 0);
      chk("m_owner", int'(bus.owner), int'(m_own));
      if (m_rdy_n < 0 || m_n == m_rdy_n) begin
        chk("m_wait_rw", int'(bus.rw), 0);
        chk("m_wait_addr", int'(bus.addr), 7);
        if (m_rdy_n < 0) begin
          cond = m_mode ? !bus.irq : bus.reg_out;
          if (cond) m_rdy_n = m_n;
          else if (m_n == int'(P_MAIN) - 1) begin
            nxt_tmo = 1; m_inflight = 0;
          end
        end
      end else if (m_n == m_rdy_n + 1) begin
        chk("m_br_rw", int'(bus.rw), 1);
        chk("m_br_addr", int'(bus.addr), 4);
        chk("m_br_data", int'(bus.data_out), int'(m_held));
      end else begin
        chk("m_sb_rw", int'(bus.rw), 1);
        chk("m_sb_addr", int'(bus.addr), 7);
        chk("m_sb_regin", int'(bus.reg_in), 0);
        m_count = m_count + 16'd1;
        m_inflight = 0;
      end
      m_n++;
    end else begin
      chk("m_idle_rw", int'(bus.rw), 0);
      chk("m_idle_addr", int'(bus.addr), 0);
      chk("m_idle_data", int'(bus.data_out), 0);
      chk("m_idle_regin", int'(bus.reg_in), 0);
      chk("m_idle_busy", int'(bus.busy), 0);
      if (m_pending || bus.mode_sel != m_mode) begin
        chk("m_cfgreq_ready", int'({bus.req1_ready, bus.req0_ready}), 0);
        m_cfg_now = 1; m_cfg_val = bus.mode_sel;
      end else if (bus.req0_valid || bus.req1_valid) begin
        g = (bus.req0_valid && bus.req1_valid) ? int'(!m_last) : (bus.req1_valid ? 1 : 0);
        chk("m_grant", int'({bus.req1_ready, bus.req0_ready}), (g == 1) ? 2 : 1);
        m_held = (g == 1) ? bus.req1_data : bus.req0_data;
        m_own = (g == 1); m_last = (g == 1);
        m_inflight = 1; m_n = 0; m_rdy_n = -1;
      end else begin
        chk("m_idle_ready", int'({bus.req1_ready, bus.req0_ready}), 0);
      end
    end
    m_tmo_pulse = nxt_tmo;
  endtask

  // Model runs every cycle; while reset is held all outputs must sit at reset values
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rw", int'(bus.rw), 0);
      chk("rst_addr", int'(bus.addr), 0);
      chk("rst_data", int'(bus.data_out), 0);
      chk("rst_regin", int'(bus.reg_in), 0);
      chk("rst_ready", int'({bus.req1_ready, bus.req0_ready}), 0);
      chk("rst_owner", int'(bus.owner), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_timeout", int'(bus.timeout_err), 0);
      chk("rst_count", int'(bus.char_count), 0);
      m_reset();
    end else begin
      model_step();
    end
  end

  // ---------------- helpers ----------------
  task automatic send(input int which, input logic [7:0] d, output int t);
    t = -1;
    @(posedge clk); #1;
    if (which == 0) begin bus.req0_valid = 1; bus.req0_data = d; end
    else begin bus2.req0_valid = 1; bus2.req0_data = d; end
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge clk);
      if ((which == 0) ? bus.req0_ready : bus2.req0_ready) t = cyc;
      else begin @(posedge clk); #1; end
    end
    chk("send_accepted", int'(t >= 0), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         v0;
    logic [7:0] d0;
    bit         v1;
    logic [7:0] d1;
    bit         rw;
    logic [2:0] addr;
    logic [7:0] dout;
    bit         regin;
    bit         r0;
    bit         r1;
    bit         busy;
    int         cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(bit v0, logic [7:0] d0, bit v1, logic [7:0] d1, bit rw,
                              logic [2:0] addr, logic [7:0] dout, bit regin, bit r0, bit r1,
                              bit busy, int cnt);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rw = rw; v.addr = addr; v.dout = dout;
    v.regin = regin; v.r0 = r0; v.r1 = r1; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    int t, br_cyc, n_pulse, tmo_cyc, n_br, cfg_cyc, g_cyc, br61, br62;
    logic [7:0] br_data;
    bit acc0, acc1;

    // Cycle-by-cycle after reset release (mode 0, reg_out=1)
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 8'h48, 0, 8'h00, 0, 3'd0, 8'h00, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 8'h00, 0, 3'd7, 8'h00, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1, 3'd4, 8'h48, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 1, 3'd7, 8'h00, 0, 0, 0, 1, 0);
    tbl[6]  = mk(1, 8'h41, 1, 8'h42, 0, 3'd0, 8'h00, 0, 0, 1, 0, 1);
    tbl[7]  = mk(1, 8'h41, 1, 8'h42, 0, 3'd7, 8'h00, 0, 0, 0, 1, 1);
    tbl[8]  = mk(1, 8'h41, 1, 8'h42, 1, 3'd4, 8'h42, 0, 0, 0, 1, 1);
    tbl[9]  = mk(1, 8'h41, 1, 8'h42, 1, 3'd7, 8'h00, 0, 0, 0, 1, 1);
    tbl[10] = mk(1, 8'h41, 1, 8'h42, 0, 3'd0, 8'h00, 0, 1, 0, 0, 2);
    tbl[11] = mk(1, 8'h41, 1, 8'h42, 0, 3'd7, 8'h00, 0, 0, 0, 1, 2);
    tbl[12] = mk(1, 8'h41, 1, 8'h42, 1, 3'd4, 8'h41, 0, 0, 0, 1, 2);
    tbl[13] = mk(1, 8'h41, 1, 8'h42, 1, 3'd7, 8'h00, 0, 0, 0, 1, 2);
    tbl[14] = mk(1, 8'h41, 1, 8'h42, 0, 3'd0, 8'h00, 0, 0, 1, 0, 3);
    tbl[15] = mk(1, 8'h41, 1, 8'h42, 0, 3'd7, 8'h00, 0, 0, 0, 1, 3);
    tbl[16] = mk(1, 8'h41, 1, 8'h42, 1, 3'd4, 8'h42, 0, 0, 0, 1, 3);
    tbl[17] = mk(1, 8'h41, 1, 8'h42, 1, 3'd7, 8'h00, 0, 0, 0, 1, 3);
    tbl[18] = mk(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 0, 4);

    rst_n = 0;
    bus.req0_valid = 0; bus.req0_data = 0; bus.req1_valid = 0; bus.req1_data = 0;
    bus.mode_sel = 0; bus.irq = 1; bus.reg_out = 1;
    bus2.req0_valid = 0; bus2.req0_data = 0; bus2.req1_valid = 0; bus2.req1_data = 0;
    bus2.mode_sel = 0; bus2.irq = 1; bus2.reg_out = 0;
    repeat (3) @(posedge clk);

    // ---- table: reset, first character, alternating grants ----
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      if (i == 0) rst_n = 1;
      bus.req0_valid = tbl[i].v0; bus.req0_data = tbl[i].d0;
      bus.req1_valid = tbl[i].v1; bus.req1_data = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("tbl%0d_rw", i), int'(bus.rw), int'(tbl[i].rw));
      chk($sformatf("tbl%0d_addr", i), int'(bus.addr), int'(tbl[i].addr));
      chk($sformatf("tbl%0d_ready", i), int'({bus.req1_ready, bus.req0_ready}),
          int'({tbl[i].r1, tbl[i].r0}));
      chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_count", i), int'(bus.char_count), tbl[i].cnt);
      if (tbl[i].addr == 3'd4 || (!tbl[i].rw && tbl[i].addr == 3'd0))
        chk($sformatf("tbl%0d_data", i), int'(bus.data_out), int'(tbl[i].dout));
      if (tbl[i].addr == 3'd0 || (tbl[i].rw && tbl[i].addr == 3'd7))
        chk($sformatf("tbl%0d_regin", i), int'(bus.reg_in), int'(tbl[i].regin));
    end

    // ---- polling: reg_out low for 10 cycles after accept ----
    @(posedge clk); #1 bus.reg_out = 0;
    send(0, 8'h55, t);
    br_cyc = -1; br_data = 0;
    for (int k = 0; k < 30 && br_cyc < 0; k++) begin
      @(posedge clk); #1;
      bus.req0_valid = 0;
      bus.reg_out = (cyc >= t + 11);
      @(negedge clk);
      if (bus.rw && bus.addr == 3'd4) begin br_cyc = cyc; br_data = bus.data_out; end
    end
    chk("poll_br_latency", br_cyc - t, 12);
    chk("poll_br_data", int'(br_data), 8'h55);
    @(posedge clk); #1 bus.reg_out = 1;

    // ---- timeout on the short-timeout instance, then normal service ----
    send(1, 8'h77, t);
    @(posedge clk); #1 bus2.req0_valid = 0;
    n_pulse = 0; tmo_cyc = -1; n_br = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus2.timeout_err) begin n_pulse++; if (tmo_cyc < 0) tmo_cyc = cyc; end
      if (bus2.rw && bus2.addr == 3'd4) n_br++;
    end
    chk("tmo_pulses", n_pulse, 1);
    chk("tmo_latency", tmo_cyc - t, 9);
    chk("tmo_no_br", n_br, 0);
    chk("tmo_count", int'(bus2.char_count), 0);
    @(posedge clk); #1 bus2.reg_out = 1;
    send(1, 8'h78, t);
    @(posedge clk); #1 bus2.req0_valid = 0;
    br_cyc = -1; br_data = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus2.rw && bus2.addr == 3'd4 && br_cyc < 0) begin br_cyc = cyc; br_data = bus2.data_out; end
    end
    chk("tmo_next_br_latency", br_cyc - t, 2);
    chk("tmo_next_br_data", int'(br_data), 8'h78);
    chk("tmo_next_count", int'(bus2.char_count), 1);

    // ---- mode change mid-transfer ----
    send(0, 8'h61, t);
    @(posedge clk); #1;
    bus.req0_valid = 0; bus.mode_sel = 1;
    bus.req1_valid = 1; bus.req1_data = 8'h62;
    cfg_cyc = -1; g_cyc = -1; br61 = -1; br62 = -1;
    for (int k = 0; k < 40 && br62 < 0; k++) begin
      @(negedge clk);
      if (bus.rw && bus.addr == 3'd0 && bus.reg_in && cfg_cyc < 0) cfg_cyc = cyc;
      if (bus.req1_ready && g_cyc < 0) g_cyc = cyc;
      if (bus.rw && bus.addr == 3'd4 && bus.data_out == 8'h61) br61 = cyc;
      if (bus.rw && bus.addr == 3'd4 && bus.data_out == 8'h62) br62 = cyc;
      @(posedge clk); #1;
      if (g_cyc >= 0) bus.req1_valid = 0;
      bus.irq = !(g_cyc >= 0 && cyc == g_cyc + 6);
    end
    bus.irq = 1;
    chk("mode_first_char_br", br61 - t, 2);
    chk("mode_cfg_seen", int'(cfg_cyc >= 0), 1);
    chk("mode_cfg_before_grant", int'(g_cyc > cfg_cyc && cfg_cyc >= 0), 1);
    chk("mode_grant_latency", g_cyc - t, 6);
    chk("mode_irq_br_latency", br62 - g_cyc, 7);

    // ---- reset during WRITE_BR ----
    @(posedge clk); #1 bus.irq = 0;
    send(0, 8'h70, t);
    @(posedge clk); #1 bus.req0_valid = 0;
    @(posedge clk); #1;
    chk("rstbr_in_br", int'(bus.rw && bus.addr == 3'd4), 1);
    rst_n = 0;
    #1;
    chk("rstbr_rw", int'(bus.rw), 0);
    chk("rstbr_addr", int'(bus.addr), 0);
    chk("rstbr_data", int'(bus.data_out), 0);
    chk("rstbr_count", int'(bus.char_count), 0);
    chk("rstbr_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1; bus.req0_valid = 1; bus.req0_data = 8'h71;
    @(negedge clk);
    chk("rstbr_c1_ready", int'(bus.req0_ready), 0);
    chk("rstbr_c1_rw", int'(bus.rw), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbr_c2_cfg", int'({bus.rw, bus.addr, bus.reg_in}), 5'b1_000_1);
    chk("rstbr_c2_ready", int'(bus.req0_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbr_c3_ready", int'(bus.req0_ready), 1);
    @(posedge clk); #1 bus.req0_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstbr_count_restart", int'(bus.char_count), 1);

    // ---- random traffic against the model ----
    acc0 = 0; acc1 = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (acc0 || !bus.req0_valid) begin
        bus.req0_valid = ($urandom % 3) != 0; bus.req0_data = 8'($urandom);
      end
      if (acc1 || !bus.req1_valid) begin
        bus.req1_valid = ($urandom % 3) != 0; bus.req1_data = 8'($urandom);
      end
      bus.reg_out = ($urandom % 4) == 0;
      bus.irq = ($urandom % 4) != 0;
      if ($urandom % 64 == 0) bus.mode_sel = ~bus.mode_sel;
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Run-length guard
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
